// File: rtl/usb_data_buffer.sv
// usb_data_buffer: byte-wide circular FIFO between the AHB-Lite slave and the
// USB RX/TX packet engines. The AHB side moves 1, 2 or 4 bytes per cycle
// (little-endian). The USB side moves one byte per cycle. Occupancy is
// registered. Overflow, underflow and port collisions raise a sticky error.
//
// Request semantics: a push or pop request is a single-cycle command that is
// sampled at the rising edge. There is no ready back-pressure. The request is
// either accepted in full or discarded in full; a discard sets buffer_error.
// Data for a pop is valid combinationally (rx_data / tx_packet_data) in the
// same cycle the pop is asserted. The pointer moves at the edge.
module usb_data_buffer #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [1:0]  get_rx_data,
  input  logic [1:0]  store_tx_data,
  input  logic [31:0] tx_data,
  output logic [31:0] rx_data,
  output logic [7:0]  buffer_occupancy,
  input  logic        clear_data_buffer,
  input  logic        store_rx_packet_data,
  input  logic [7:0]  rx_packet_data,
  input  logic        get_tx_packet_data,
  output logic [7:0]  tx_packet_data,
  output logic        buffer_error
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    count;
  logic          err;

  logic [2:0] push_n;
  logic [2:0] pop_n;
  logic       push_collide;
  logic       pop_collide;
  logic       push_ok;
  logic       pop_ok;
  logic       push_bad;
  logic       pop_bad;
  logic [7:0] push_byte [4];

  // Request code to byte count: 0, 1, 2 or 4.
  function automatic logic [2:0] decode_n(input logic [1:0] req);
    logic [2:0] n;
    case (req)
      2'd1:    n = 3'd1;
      2'd2:    n = 3'd2;
      2'd3:    n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  // Arbitrate each side (USB wins) and judge the winners against the old count.
  always_comb begin
    push_collide = store_rx_packet_data && (store_tx_data != 2'd0);
    pop_collide  = get_tx_packet_data && (get_rx_data != 2'd0);
    push_n       = store_rx_packet_data ? 3'd1 : decode_n(store_tx_data);
    pop_n        = get_tx_packet_data ? 3'd1 : decode_n(get_rx_data);
    push_ok      = (push_n != 3'd0) && (({1'b0, count} + {6'd0, push_n}) <= DEPTH_W);
    push_bad     = (push_n != 3'd0) && !push_ok;
    pop_ok       = (pop_n != 3'd0) && ({5'd0, pop_n} <= count);
    pop_bad      = (pop_n != 3'd0) && !pop_ok;
    push_byte[0] = store_rx_packet_data ? rx_packet_data : tx_data[7:0];
    push_byte[1] = tx_data[15:8];
    push_byte[2] = tx_data[23:16];
    push_byte[3] = tx_data[31:24];
  end

  // Storage array: written on accepted pushes only, never cleared.
  always_ff @(posedge clk) begin
    if (push_ok && !clear_data_buffer) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < push_n) mem[wr_ptr + AW'(i)] <= push_byte[i];
      end
    end
  end

  // Pointers, occupancy and sticky error; a flush overrides all requests.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 8'd0;
      err    <= 1'b0;
    end else if (clear_data_buffer) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 8'd0;
      err    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(push_n);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(pop_n);
      count <= count + (push_ok ? {5'd0, push_n} : 8'd0)
                     - (pop_ok  ? {5'd0, pop_n}  : 8'd0);
      if (push_collide || pop_collide || push_bad || pop_bad) err <= 1'b1;
    end
  end

  // Head view: up to four bytes from the read pointer; bytes past count read 0.
  always_comb begin
    rx_data = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (8'(i) < count) rx_data[8*i +: 8] = mem[rd_ptr + AW'(i)];
    end
    tx_packet_data = (count != 8'd0) ? mem[rd_ptr] : 8'd0;
  end

  assign buffer_occupancy = count;
  assign buffer_error     = err;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Testbench for usb_data_buffer: directed scenarios plus a randomized run,
// all checked against a byte-queue reference model of the FIFO.
module tb_usb_data_buffer;

  logic        clk;
  logic        n_rst;
  logic [1:0]  get_rx_data;
  logic [1:0]  store_tx_data;
  logic [31:0] tx_data;
  logic [31:0] rx_data;
  logic [7:0]  buffer_occupancy;
  logic        clear_data_buffer;
  logic        store_rx_packet_data;
  logic [7:0]  rx_packet_data;
  logic        get_tx_packet_data;
  logic [7:0]  tx_packet_data;
  logic        buffer_error;

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO contents in order (head first) plus sticky error.
  logic [7:0] exp_q[$];
  logic       exp_err;

  usb_data_buffer #(.DEPTH(64)) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .get_rx_data          (get_rx_data),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .rx_data              (rx_data),
    .buffer_occupancy     (buffer_occupancy),
    .clear_data_buffer    (clear_data_buffer),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .buffer_error         (buffer_error)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int req_bytes(input logic [1:0] r);
    return (r == 2'd3) ? 4 : int'(r);
  endfunction

  function automatic logic [31:0] exp_rx_word();
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < 4; i++) if (i < exp_q.size()) w[8*i +: 8] = exp_q[i];
    return w;
  endfunction

  function automatic logic [7:0] exp_head();
    return (exp_q.size() != 0) ? exp_q[0] : 8'd0;
  endfunction

  // Model of one clock edge, written from the FIFO rules on a byte queue.
  task automatic model_step(input logic [1:0] gr, input logic [1:0] st,
                            input logic [31:0] td, input logic srx,
                            input logic [7:0] rd, input logic gtx,
                            input logic clr);
    int old_cnt, pn, qn;
    if (clr) begin
      exp_q.delete();
      exp_err = 1'b0;
      return;
    end
    old_cnt = exp_q.size();
    pn = srx ? 1 : req_bytes(st);
    qn = gtx ? 1 : req_bytes(gr);
    if (srx && st != 2'd0) exp_err = 1'b1;
    if (gtx && gr != 2'd0) exp_err = 1'b1;
    if (pn != 0 && old_cnt + pn > 64) exp_err = 1'b1;
    if (qn != 0 && qn > old_cnt) exp_err = 1'b1;
    if (qn != 0 && qn <= old_cnt) repeat (qn) void'(exp_q.pop_front());
    if (pn != 0 && old_cnt + pn <= 64) begin
      if (srx) exp_q.push_back(rd);
      else for (int i = 0; i < pn; i++) exp_q.push_back(td[8*i +: 8]);
    end
  endtask

  // Driver: apply one cycle of requests from a falling edge, return at the next.
  task automatic drive(input logic [1:0] gr, input logic [1:0] st,
                       input logic [31:0] td, input logic srx,
                       input logic [7:0] rd, input logic gtx,
                       input logic clr);
    get_rx_data          = gr;
    store_tx_data        = st;
    tx_data              = td;
    store_rx_packet_data = srx;
    rx_packet_data       = rd;
    get_tx_packet_data   = gtx;
    clear_data_buffer    = clr;
    @(posedge clk);
    model_step(gr, st, td, srx, rd, gtx, clr);
    @(negedge clk);
    get_rx_data          = 2'd0;
    store_tx_data        = 2'd0;
    tx_data              = 32'd0;
    store_rx_packet_data = 1'b0;
    rx_packet_data       = 8'd0;
    get_tx_packet_data   = 1'b0;
    clear_data_buffer    = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (buffer_occupancy !== 8'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", buffer_occupancy); end
    checks++; if (buffer_error !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", buffer_error); end
    checks++; if (rx_data !== 32'd0) begin errors++; $display("FAIL reset_rx: got %h expected 00000000", rx_data); end
    checks++; if (tx_packet_data !== 8'd0) begin errors++; $display("FAIL reset_tx: got %h expected 00", tx_packet_data); end
    n_rst = 1'b1;
    @(negedge clk);
    // Asynchronous reset in the middle of a cycle with data present.
    drive(2'd0, 2'd3, 32'h11223344, 1'b0, 8'd0, 1'b0, 1'b0);
    drive(2'd0, 2'd1, 32'h000000EE, 1'b0, 8'd0, 1'b0, 1'b0);
    #2 n_rst = 1'b0;
    #1;
    exp_q.delete();
    exp_err = 1'b0;
    checks++; if (buffer_occupancy !== 8'd0) begin errors++; $display("FAIL async_reset_occ: got %0d expected 0", buffer_occupancy); end
    checks++; if (rx_data !== 32'd0) begin errors++; $display("FAIL async_reset_rx: got %h expected 00000000", rx_data); end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_ahb_push();
    drive(2'd0, 2'd3, 32'hDDCCBBAA, 1'b0, 8'd0, 1'b0, 1'b0);
    checks++; if (buffer_occupancy !== 8'd4) begin errors++; $display("FAIL push_occ: got %0d expected 4", buffer_occupancy); end
    checks++; if (rx_data !== 32'hDDCCBBAA) begin errors++; $display("FAIL push_rx: got %h expected ddccbbaa", rx_data); end
    checks++; if (tx_packet_data !== 8'hAA) begin errors++; $display("FAIL push_head: got %h expected aa", tx_packet_data); end
  endtask

  task automatic test_usb_pop();
    logic [31:0] seq;
    seq = 32'hDDCCBBAA;
    for (int i = 0; i < 4; i++) begin
      checks++; if (tx_packet_data !== seq[8*i +: 8]) begin errors++; $display("FAIL usb_pop_byte%0d: got %h expected %h", i, tx_packet_data, seq[8*i +: 8]); end
      checks++; if (buffer_occupancy !== 8'(4 - i)) begin errors++; $display("FAIL usb_pop_occ%0d: got %0d expected %0d", i, buffer_occupancy, 4 - i); end
      drive(2'd0, 2'd0, 32'd0, 1'b0, 8'd0, 1'b1, 1'b0);
    end
    checks++; if (buffer_occupancy !== 8'd0) begin errors++; $display("FAIL usb_pop_empty_occ: got %0d expected 0", buffer_occupancy); end
    checks++; if (rx_data !== 32'd0) begin errors++; $display("FAIL usb_pop_empty_rx: got %h expected 00000000", rx_data); end
    checks++; if (buffer_error !== 1'b0) begin errors++; $display("FAIL usb_pop_err: got %b expected 0", buffer_error); end
  endtask

  task automatic test_overflow_clear();
    for (int i = 0; i < 62; i++) drive(2'd0, 2'd0, 32'd0, 1'b1, 8'(i + 1), 1'b0, 1'b0);
    checks++; if (buffer_occupancy !== 8'd62) begin errors++; $display("FAIL fill_occ: got %0d expected 62", buffer_occupancy); end
    drive(2'd0, 2'd3, 32'hA5A5A5A5, 1'b0, 8'd0, 1'b0, 1'b0);
    checks++; if (buffer_occupancy !== 8'd62) begin errors++; $display("FAIL overflow_occ: got %0d expected 62", buffer_occupancy); end
    checks++; if (buffer_error !== 1'b1) begin errors++; $display("FAIL overflow_err: got %b expected 1", buffer_error); end
    checks++; if (tx_packet_data !== 8'd1) begin errors++; $display("FAIL overflow_head: got %h expected 01", tx_packet_data); end
    drive(2'd0, 2'd2, 32'h0000F2F1, 1'b0, 8'd0, 1'b0, 1'b0);
    checks++; if (buffer_occupancy !== 8'd64) begin errors++; $display("FAIL full_occ: got %0d expected 64", buffer_occupancy); end
    // Push into a full buffer fails even with a pop in the same cycle.
    drive(2'd0, 2'd0, 32'd0, 1'b1, 8'h77, 1'b1, 1'b0);
    checks++; if (buffer_occupancy !== 8'd63) begin errors++; $display("FAIL full_pushpop_occ: got %0d expected 63", buffer_occupancy); end
    checks++; if (tx_packet_data !== 8'd2) begin errors++; $display("FAIL full_pushpop_head: got %h expected 02", tx_packet_data); end
    drive(2'd0, 2'd0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    checks++; if (buffer_occupancy !== 8'd0) begin errors++; $display("FAIL clear_occ: got %0d expected 0", buffer_occupancy); end
    checks++; if (buffer_error !== 1'b0) begin errors++; $display("FAIL clear_err: got %b expected 0", buffer_error); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 31; i++) begin
      drive(2'd0, 2'd2, $urandom, 1'b0, 8'd0, 1'b0, 1'b0);
      drive(2'd2, 2'd0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    end
    checks++; if (buffer_occupancy !== 8'd0) begin errors++; $display("FAIL wrap_pre_occ: got %0d expected 0", buffer_occupancy); end
    drive(2'd0, 2'd3, 32'h04030201, 1'b0, 8'd0, 1'b0, 1'b0);
    checks++; if (buffer_occupancy !== 8'd4) begin errors++; $display("FAIL wrap_occ: got %0d expected 4", buffer_occupancy); end
    checks++; if (rx_data !== 32'h04030201) begin errors++; $display("FAIL wrap_rx: got %h expected 04030201", rx_data); end
    checks++; if (tx_packet_data !== 8'h01) begin errors++; $display("FAIL wrap_head: got %h expected 01", tx_packet_data); end
    drive(2'd3, 2'd0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    checks++; if (buffer_occupancy !== 8'd0) begin errors++; $display("FAIL wrap_pop_occ: got %0d expected 0", buffer_occupancy); end
    checks++; if (buffer_error !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b expected 0", buffer_error); end
  endtask

  task automatic test_collision();
    drive(2'd0, 2'd1, 32'h000000EE, 1'b1, 8'h55, 1'b0, 1'b0);
    checks++; if (buffer_occupancy !== 8'd1) begin errors++; $display("FAIL push_coll_occ: got %0d expected 1", buffer_occupancy); end
    checks++; if (tx_packet_data !== 8'h55) begin errors++; $display("FAIL push_coll_head: got %h expected 55", tx_packet_data); end
    checks++; if (buffer_error !== 1'b1) begin errors++; $display("FAIL push_coll_err: got %b expected 1", buffer_error); end
    drive(2'd0, 2'd0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    drive(2'd0, 2'd2, 32'h00006655, 1'b0, 8'd0, 1'b0, 1'b0);
    drive(2'd3, 2'd0, 32'd0, 1'b0, 8'd0, 1'b1, 1'b0);
    checks++; if (buffer_occupancy !== 8'd1) begin errors++; $display("FAIL pop_coll_occ: got %0d expected 1", buffer_occupancy); end
    checks++; if (tx_packet_data !== 8'h66) begin errors++; $display("FAIL pop_coll_head: got %h expected 66", tx_packet_data); end
    checks++; if (buffer_error !== 1'b1) begin errors++; $display("FAIL pop_coll_err: got %b expected 1", buffer_error); end
    drive(2'd0, 2'd0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b1);
  endtask

  task automatic test_underflow_simul();
    drive(2'd0, 2'd1, 32'h0000003C, 1'b0, 8'd0, 1'b0, 1'b0);
    drive(2'd2, 2'd0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    checks++; if (buffer_occupancy !== 8'd1) begin errors++; $display("FAIL underflow_occ: got %0d expected 1", buffer_occupancy); end
    checks++; if (buffer_error !== 1'b1) begin errors++; $display("FAIL underflow_err: got %b expected 1", buffer_error); end
    checks++; if (rx_data !== 32'h0000003C) begin errors++; $display("FAIL underflow_rx: got %h expected 0000003c", rx_data); end
    drive(2'd0, 2'd0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    drive(2'd0, 2'd3, 32'h44332211, 1'b0, 8'd0, 1'b0, 1'b0);
    drive(2'd0, 2'd3, 32'h88776655, 1'b0, 8'd0, 1'b0, 1'b0);
    checks++; if (buffer_occupancy !== 8'd8) begin errors++; $display("FAIL eight_occ: got %0d expected 8", buffer_occupancy); end
    drive(2'd2, 2'd3, 32'hCCBBAA99, 1'b0, 8'd0, 1'b0, 1'b0);
    checks++; if (buffer_occupancy !== 8'd10) begin errors++; $display("FAIL simul_occ: got %0d expected 10", buffer_occupancy); end
    checks++; if (rx_data !== 32'h66554433) begin errors++; $display("FAIL simul_rx: got %h expected 66554433", rx_data); end
    checks++; if (buffer_error !== 1'b0) begin errors++; $display("FAIL simul_err: got %b expected 0", buffer_error); end
    // A flush with illegal requests alongside leaves no error behind.
    drive(2'd3, 2'd3, 32'hFFFFFFFF, 1'b1, 8'hFF, 1'b1, 1'b1);
    checks++; if (buffer_occupancy !== 8'd0) begin errors++; $display("FAIL clear_busy_occ: got %0d expected 0", buffer_occupancy); end
    checks++; if (buffer_error !== 1'b0) begin errors++; $display("FAIL clear_busy_err: got %b expected 0", buffer_error); end
  endtask

  task automatic test_random();
    logic [1:0] gr, st;
    logic       srx, gtx, clr;
    for (int c = 0; c < 500; c++) begin
      srx = ($urandom_range(0, 3) == 0);
      gtx = ($urandom_range(0, 4) == 0);
      st  = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'd0;
      gr  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      clr = ($urandom_range(0, 79) == 0);
      drive(gr, st, $urandom, srx, 8'($urandom), gtx, clr);
      checks++; if (buffer_occupancy !== 8'(exp_q.size())) begin errors++; $display("FAIL rand_occ c%0d: got %0d expected %0d", c, buffer_occupancy, exp_q.size()); end
      checks++; if (rx_data !== exp_rx_word()) begin errors++; $display("FAIL rand_rx c%0d: got %h expected %h", c, rx_data, exp_rx_word()); end
      checks++; if (tx_packet_data !== exp_head()) begin errors++; $display("FAIL rand_tx c%0d: got %h expected %h", c, tx_packet_data, exp_head()); end
      checks++; if (buffer_error !== exp_err) begin errors++; $display("FAIL rand_err c%0d: got %b expected %b", c, buffer_error, exp_err); end
    end
  endtask

  // Sequence of scenarios and final report.
  initial begin
    exp_err              = 1'b0;
    get_rx_data          = 2'd0;
    store_tx_data        = 2'd0;
    tx_data              = 32'd0;
    store_rx_packet_data = 1'b0;
    rx_packet_data       = 8'd0;
    get_tx_packet_data   = 1'b0;
    clear_data_buffer    = 1'b0;
    test_reset();
    test_ahb_push();
    test_usb_pop();
    test_overflow_clear();
    test_wrap();
    test_collision();
    test_underflow_simul();
    drive(2'd0, 2'd0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_data_buffer.md
# usb_data_buffer

64-byte circular FIFO shared by the AHB-Lite slave and the USB RX/TX packet engines. It sits directly behind the slave's data-buffer port. The AHB side pushes or pops 1, 2 or 4 bytes per cycle (little-endian) and sees a live occupancy count. The USB side pushes received bytes and pops bytes for transmission, one per cycle. Overflow, underflow and port collisions are recorded in a sticky error flag.

## Interface
- DEPTH, 64, buffer size in bytes; must be a power of two, ≤128
- clk  in  1  system clock, all state on rising edge
- n_rst  in  1  asynchronous, active-low reset
- get_rx_data  in  2  AHB pop request: 0 none, 1 = 1 byte, 2 = 2 bytes, 3 = 4 bytes
- store_tx_data  in  2  AHB push request, same encoding
- tx_data  in  32  AHB push data; byte 0 = bits[7:0] is written first
- rx_data  out  32  combinational view of the next 4 bytes at the read pointer; byte 0 = head; bytes at index ≥ occupancy read 0
- buffer_occupancy  out  8  registered byte count, 0..DEPTH
- clear_data_buffer  in  1  synchronous flush
- store_rx_packet_data  in  1  USB RX push of one byte
- rx_packet_data  in  8  USB RX byte
- get_tx_packet_data  in  1  USB TX pop of one byte
- tx_packet_data  out  8  combinational head byte; 0 when empty
- buffer_error  out  1  sticky error flag

## Operation
- State:
  - DEPTH×8 memory
  - wr_ptr and rd_ptr, log2(DEPTH) bits each, wrapping modulo DEPTH
  - count, 8 bits
  - err flag
- Decode n = {0,1,2,4} from each 2-bit request.
- **Push side:**
  - The USB push has priority.
  - If store_rx_packet_data and store_tx_data≠0 are both asserted, the USB byte is pushed, the AHB push is discarded, and err is set.
- **Pop side:**
  - The USB pop has priority.
  - If get_tx_packet_data and get_rx_data≠0 are both asserted, one byte is popped for USB, the AHB pop is discarded, and err is set.
- **Overflow:** if a push of n bytes has count + n > DEPTH, using count at the start of the cycle, the entire push is discarded and err is set. There are no partial pushes.
- **Underflow:** if a pop of n bytes has n > count, the entire pop is discarded and err is set. rx_data and tx_packet_data are unaffected by the discard.
- **Accepted push:**
  - Byte i goes to mem[wr_ptr+i mod DEPTH].
  - wr_ptr advances by n.
- **Accepted pop:** rd_ptr advances by n.
- **Simultaneous push and pop:**
  - Both are evaluated against the old count.
  - count_next = count + pushed − popped.
  - Popping at a full buffer and pushing at an empty buffer both follow the old-count rule: a push into a full buffer errors even if a pop occurs in the same cycle.
- **clear_data_buffer:**
  - Highest priority.
  - Next cycle: wr_ptr = rd_ptr = 0, count = 0, err = 0.
  - All pushes and pops in the same cycle are ignored and set no error.
- Memory contents are never cleared; only pointers and count are reset.

## Timing
- **Reset:**
  - wr_ptr = rd_ptr = 0, count = 0, err = 0.
  - Outputs: buffer_occupancy = 0, buffer_error = 0, rx_data = 0, tx_packet_data = 0.
- **Push-to-visible latency:** 1 cycle. Bytes pushed at edge k appear on rx_data / tx_packet_data and in buffer_occupancy after edge k.
- **Pop:** the head is valid in the same cycle the pop is asserted. The consumer samples rx_data or tx_packet_data while asserting the request, and the pointer advances at the edge.
- **Back-to-back pops:** permitted every cycle without bubbles.
- **buffer_occupancy:** always equals count; no combinational path from request inputs.
- **buffer_error:** rises one cycle after the offending request and holds until clear_data_buffer or reset.
- **Wrap-around:** a multi-byte push or pop straddling index DEPTH−1→0 must be handled within the same single cycle.
- **Reset mid-operation:** asynchronous reset immediately returns all state to reset values. Partially written words are lost.

## Test plan
- Reset, then AHB push store_tx_data=3 with tx_data=0xDDCCBBAA → next cycle occupancy=4, rx_data=0xDDCCBBAA, tx_packet_data=0xAA.
- With 4 bytes present, pop get_tx_packet_data for 4 cycles → tx_packet_data = AA, BB, CC, DD in sequence; occupancy 4→0; final rx_data=0.
- Fill to 62 bytes via USB, then AHB push of 4 bytes → push discarded, occupancy stays 62, buffer_error=1. Then clear → occupancy=0, error=0.
- Advance pointers to 62, push 4 bytes 0x04030201, pop 4 via AHB → rx_data=0x04030201 read correctly across the wrap; occupancy returns to 0.
- Same cycle: store_rx_packet_data=1 (0x55) and store_tx_data=1 → occupancy +1, head=0x55, buffer_error=1.
- Occupancy 1, AHB get_rx_data=2 → pop discarded, occupancy stays 1, error=1. Separately, with occupancy 8, simultaneous 4-byte push and 2-byte pop → occupancy 10.
